// File: rtl/shift_reg_pkg.sv
// Shared encodings for the 4-bit shift register command sequencer.
package shift_reg_pkg;

  localparam int REG_W = 4;
  localparam int CNT_W = 3;

  localparam logic [1:0] MODO_SHIFT = 2'b00;
  localparam logic [1:0] MODO_ROT   = 2'b01;
  localparam logic [1:0] MODO_LOAD  = 2'b10;
  localparam logic [1:0] MODO_HOLD  = 2'b11;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SHIFT  = 2'b01,
    OP_ROTATE = 2'b10,
    OP_SEND   = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // One control word as seen by the register.
  typedef struct packed {
    logic             enb;
    logic             dir;
    logic             s_in;
    logic [1:0]       modo;
    logic [REG_W-1:0] d;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{enb: 1'b0, dir: 1'b0, s_in: 1'b0, modo: MODO_HOLD, d: '0};

endpackage

// File: rtl/shift_reg_ctrl.sv
// Command sequencer: expands LOAD/SHIFT/ROTATE/SEND into cycle-exact register
// control words and captures the serialized S_OUT stream.
module shift_reg_ctrl
  import shift_reg_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [REG_W-1:0] CMD_DATA,
  input  logic             CMD_DIR,
  input  logic             CMD_SIN,
  input  logic [CNT_W-1:0] CMD_CNT,
  output logic             ENB,
  output logic             DIR,
  output logic             S_IN,
  output logic [1:0]       MODO,
  output logic [REG_W-1:0] D,
  input  logic [REG_W-1:0] Q,
  input  logic             S_OUT,
  output logic             DONE,
  output logic [REG_W-1:0] RX_DATA,
  output logic [REG_W-1:0] Q_CAP
);

  state_e           state_q, state_n;
  cmd_op_e          op_q;
  logic [REG_W-1:0] data_q;
  logic             dir_q, sin_q;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            ctrl_q, ctrl_n;
  logic             done_q;
  logic [REG_W-1:0] rx_q, qcap_q;
  logic             accept;

  // Effective command fields: the live bus on the acceptance edge, else the latch.
  cmd_op_e          op_e;
  logic [REG_W-1:0] data_e;
  logic             dir_e, sin_e;

  assign CMD_READY = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept    = CMD_VALID && CMD_READY;

  assign op_e   = accept ? cmd_op_e'(CMD_OP) : op_q;
  assign data_e = accept ? CMD_DATA : data_q;
  assign dir_e  = accept ? CMD_DIR  : dir_q;
  assign sin_e  = accept ? CMD_SIN  : sin_q;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  // Next state, plus the control word that state will present (outputs are registered).
  always_comb begin
    state_n = state_q;
    ctrl_n  = CTRL_IDLE;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (op_e == OP_LOAD || op_e == OP_SEND) state_n = ST_LOAD;
          else if (CMD_CNT != '0)                 state_n = ST_STEP;
          else                                    state_n = ST_DONE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: state_n = (op_q == OP_LOAD || cnt_q == '0) ? ST_DONE : ST_STEP;
      ST_STEP: state_n = (cnt_q <= 3'd1) ? ST_DONE : ST_STEP;
      default: state_n = ST_IDLE;
    endcase

    case (state_n)
      ST_LOAD: begin
        ctrl_n.enb  = 1'b1;
        ctrl_n.modo = MODO_LOAD;
        ctrl_n.d    = data_e;
      end
      ST_STEP: begin
        ctrl_n.enb  = 1'b1;
        ctrl_n.dir  = dir_e;
        ctrl_n.modo = (op_e == OP_ROTATE) ? MODO_ROT : MODO_SHIFT;
        ctrl_n.s_in = (op_e == OP_ROTATE) ? 1'b0 : sin_e;
      end
      default: ctrl_n = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_q <= CTRL_IDLE;
      done_q <= 1'b0;
      rx_q   <= '0;
      qcap_q <= '0;
      op_q   <= OP_LOAD;
      data_q <= '0;
      dir_q  <= 1'b0;
      sin_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_n;
      done_q <= (state_n == ST_DONE);
      if (accept) begin
        op_q   <= cmd_op_e'(CMD_OP);
        data_q <= CMD_DATA;
        dir_q  <= CMD_DIR;
        sin_q  <= CMD_SIN;
        cnt_q  <= CMD_CNT;
        rx_q   <= '0;
      end else if (state_q == ST_STEP) begin
        // The register performs the step on this edge; S_OUT is the bit leaving it.
        cnt_q <= cnt_q - 3'd1;
        rx_q  <= {rx_q[REG_W-2:0], S_OUT};
      end
      // Q already holds the post-final-step contents during the DONE cycle.
      if (state_q == ST_DONE) qcap_q <= Q;
    end
  end

  assign ENB     = ctrl_q.enb;
  assign DIR     = ctrl_q.dir;
  assign S_IN    = ctrl_q.s_in;
  assign MODO    = ctrl_q.modo;
  assign D       = ctrl_q.d;
  assign DONE    = done_q;
  assign RX_DATA = rx_q;
  assign Q_CAP   = qcap_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench: a behavioural 4-bit register drives Q/S_OUT, and each
// command's control schedule, DONE latency, RX_DATA and Q_CAP are predicted from the command.
module tb_shift_reg_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD_OP = 2'b00;
  logic [3:0] CMD_DATA = 4'h0;
  logic       CMD_DIR = 1'b0, CMD_SIN = 1'b0;
  logic [2:0] CMD_CNT = 3'd0;
  logic       ENB, DIR, S_IN, DONE, S_OUT;
  logic [1:0] MODO;
  logic [3:0] D, Q, RX_DATA, Q_CAP;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    bit         dir;
    bit         sin;
    logic [2:0] cnt;
  } cmd_t;

  shift_reg_ctrl dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .CMD_DIR(CMD_DIR), .CMD_SIN(CMD_SIN),
    .CMD_CNT(CMD_CNT), .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO), .D(D),
    .Q(Q), .S_OUT(S_OUT), .DONE(DONE), .RX_DATA(RX_DATA), .Q_CAP(Q_CAP)
  );

  always #5 CLK = ~CLK;

  // One register step in plain arithmetic: DIR=0 moves toward the MSB, DIR=1 toward the LSB.
  function automatic logic [3:0] step_fn(logic [3:0] q, bit rot, bit dir, bit sin);
    int v;
    int fill;
    v = int'(q);
    if (dir) begin
      fill = rot ? (v & 1) : int'(sin);
      return 4'((v >> 1) | (fill << 3));
    end
    fill = rot ? ((v >> 3) & 1) : int'(sin);
    return 4'(((v << 1) | fill) & 15);
  endfunction

  function automatic bit out_fn(logic [3:0] q, bit dir);
    return dir ? q[0] : q[3];
  endfunction

  // Register under control of the DUT.
  logic [3:0] reg_q = 4'h0;
  assign Q     = reg_q;
  assign S_OUT = out_fn(reg_q, DIR);
  always @(posedge CLK) begin
    if (ENB) begin
      case (MODO)
        2'b10:   reg_q <= D;
        2'b00:   reg_q <= step_fn(reg_q, 1'b0, DIR, S_IN);
        2'b01:   reg_q <= step_fn(reg_q, 1'b1, DIR, S_IN);
        default: reg_q <= reg_q;
      endcase
    end
  end

  logic [3:0] mq = 4'h0;   // predicted register contents

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic drive(input cmd_t c, input bit v);
    CMD_VALID = v;
    CMD_OP    = c.op;
    CMD_DATA  = c.data;
    CMD_DIR   = c.dir;
    CMD_SIN   = c.sin;
    CMD_CNT   = c.cnt;
  endtask

  task automatic scramble();
    CMD_OP   = 2'($urandom);
    CMD_DATA = 4'($urandom);
    CMD_DIR  = 1'($urandom);
    CMD_SIN  = 1'($urandom);
    CMD_CNT  = 3'($urandom);
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op   = 2'($urandom_range(0, 3));
    c.data = 4'($urandom);
    c.dir  = 1'($urandom);
    c.sin  = 1'($urandom);
    c.cnt  = 3'($urandom_range(0, 7));
    return c;
  endfunction

  // Present a command until accepted; returns at posedge+1 of the acceptance edge.
  task automatic issue(input cmd_t c);
    @(negedge CLK);
    drive(c, 1'b1);
    for (int i = 0; i < 20 && !CMD_READY; i++) @(negedge CLK);
    vectors++;
    if (CMD_READY !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait ready=%b required=1", CMD_READY);
    end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    scramble();
  endtask

  // Entered at posedge+1 of the acceptance edge; returns at posedge+1 after the DONE cycle.
  task automatic expect_cmd(input cmd_t c, input bit jitter, input bit has_nxt,
                            input cmd_t nxt, input string tag);
    int         lat;
    bit         rot, ld;
    logic [3:0] rx_exp;
    logic [10:0] obs, exp_w, msk;
    rx_exp = 4'h0;
    rot = (c.op == 2'b10);
    ld  = (c.op == 2'b00) || (c.op == 2'b11);
    lat = (c.op == 2'b00) ? 2 : (c.op == 2'b11) ? int'(c.cnt) + 2 : int'(c.cnt) + 1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge CLK);
      obs = {ENB, MODO, D, DIR, S_IN, DONE, CMD_READY};
      if (k < lat) begin
        if (ld && k == 1) begin
          exp_w = {1'b1, 2'b10, c.data, 1'b0, 1'b0, 1'b0, 1'b0};
          msk   = 11'b111_1111_0011;
          mq    = c.data;
        end else begin
          exp_w = {1'b1, rot ? 2'b01 : 2'b00, 4'h0, c.dir, rot ? 1'b0 : c.sin, 1'b0, 1'b0};
          msk   = 11'b111_0000_1111;
          rx_exp = {rx_exp[2:0], out_fn(mq, c.dir)};
          mq     = step_fn(mq, rot, c.dir, c.sin);
        end
        if (jitter) begin
          CMD_VALID = 1'($urandom);
          scramble();
        end
      end else begin
        exp_w = {1'b0, 2'b11, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        msk   = '1;
        vectors++;
        if (RX_DATA !== rx_exp) begin
          errors++;
          $display("FAIL %s rx_data got=%b exp=%b", tag, RX_DATA, rx_exp);
        end
        if (has_nxt) drive(nxt, 1'b1);
        else         CMD_VALID = 1'b0;
      end
      vectors++;
      if ((obs & msk) !== (exp_w & msk)) begin
        errors++;
        $display("FAIL %s ctrl cycle %0d got={enb,modo,d,dir,sin,done,rdy}=%b exp=%b mask=%b",
                 tag, k, obs, exp_w, msk);
      end
    end
    @(posedge CLK); #1;
    vectors++;
    if (Q_CAP !== mq) begin
      errors++;
      $display("FAIL %s q_cap got=%b exp=%b", tag, Q_CAP, mq);
    end
  endtask

  task automatic test_reset();
    cmd_t c;
    c = '{op: 2'b00, data: 4'hF, dir: 1'b0, sin: 1'b0, cnt: 3'd0};
    RESET = 1'b1;
    drive(c, 1'b1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if ({ENB, MODO, D, DIR, S_IN, DONE, CMD_READY, RX_DATA, Q_CAP} !== {1'b0, 2'b11, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", {ENB, MODO, D, DIR, S_IN, DONE, CMD_READY, RX_DATA, Q_CAP},
               {1'b0, 2'b11, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0});
    end
    RESET = 1'b0;
    CMD_VALID = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({ENB, DONE, CMD_READY} !== 3'b001) begin
      errors++;
      $display("FAIL reset_no_accept got={enb,done,rdy}=%b exp=001", {ENB, DONE, CMD_READY});
    end
  endtask

  task automatic run_one(input cmd_t c, input string tag);
    cmd_t none;
    none = c;
    issue(c);
    expect_cmd(c, 1'b0, 1'b0, none, tag);
  endtask

  task automatic test_directed();
    run_one('{op: 2'b00, data: 4'b1010, dir: 1'b0, sin: 1'b0, cnt: 3'd0}, "load_1010");
    run_one('{op: 2'b01, data: 4'b0000, dir: 1'b0, sin: 1'b1, cnt: 3'd2}, "shift_2");
    run_one('{op: 2'b11, data: 4'b0110, dir: 1'b1, sin: 1'b0, cnt: 3'd4}, "send_0110");
    run_one('{op: 2'b10, data: 4'b0000, dir: 1'b1, sin: 1'b1, cnt: 3'd0}, "rotate_0");
    run_one('{op: 2'b01, data: 4'b0000, dir: 1'b1, sin: 1'b1, cnt: 3'd7}, "shift_7");
    run_one('{op: 2'b11, data: 4'b1001, dir: 1'b0, sin: 1'b1, cnt: 3'd0}, "send_0");
  endtask

  task automatic test_abort();
    cmd_t c;
    bit   seen;
    c = '{op: 2'b11, data: 4'b0110, dir: 1'b1, sin: 1'b0, cnt: 3'd4};
    issue(c);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;              // during the second STEP cycle
    mq = step_fn(step_fn(4'b0110, 1'b0, 1'b1, 1'b0), 1'b0, 1'b1, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    vectors++;
    if ({ENB, MODO, DONE, CMD_READY, RX_DATA, Q_CAP} !== {1'b0, 2'b11, 1'b0, 1'b1, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL abort_idle got=%b exp=%b", {ENB, MODO, DONE, CMD_READY, RX_DATA, Q_CAP},
               {1'b0, 2'b11, 1'b0, 1'b1, 4'h0, 4'h0});
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (DONE === 1'b1 || ENB === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      errors++;
      $display("FAIL abort_quiet activity_seen=1 required=0");
    end
    run_one('{op: 2'b00, data: 4'b1111, dir: 1'b0, sin: 1'b0, cnt: 3'd0}, "load_after_abort");
  endtask

  task automatic test_back_to_back();
    cmd_t c1, c2, none;
    c1 = '{op: 2'b00, data: 4'b0001, dir: 1'b0, sin: 1'b0, cnt: 3'd0};
    c2 = '{op: 2'b10, data: 4'b0000, dir: 1'b0, sin: 1'b0, cnt: 3'd3};
    none = c1;
    @(negedge CLK);
    drive(c1, 1'b1);
    @(posedge CLK); #1;
    drive(c2, 1'b1);
    expect_cmd(c1, 1'b1, 1'b1, c2, "b2b_load");
    CMD_VALID = 1'b0;
    scramble();
    expect_cmd(c2, 1'b1, 1'b0, none, "b2b_rotate");
  endtask

  task automatic test_random();
    cmd_t c, nxt;
    bit   chained;
    chained = 1'b0;
    c = rand_cmd();
    for (int i = 0; i < 30; i++) begin
      bit chain;
      if (!chained) issue(c);
      nxt   = rand_cmd();
      chain = (i < 29) && 1'($urandom);
      expect_cmd(c, 1'($urandom), chain, nxt, "random");
      if (chain) begin
        CMD_VALID = 1'b0;
        scramble();
      end
      chained = chain;
      c = nxt;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
